// File: rtl/pong_pkg.sv
// Shared types for the score keeper: FSM states, BCD digits and the
// saturating two-digit BCD increment.
package pong_pkg;

    typedef logic [3:0] bcd_t;

    typedef enum logic [1:0] {
        StIdle,
        StPlay,
        StHold,
        StOver
    } state_e;

    typedef struct packed {
        bcd_t tens;
        bcd_t ones;
    } score_t;

    // Digit code the display driver shows for a blanked digit.
    localparam bcd_t BLANK_CODE = 4'hF;

    // Two-digit BCD increment that saturates at 99.
    function automatic score_t bcd_inc(input score_t s);
        score_t r;
        r = s;
        if (s.tens == 4'd9 && s.ones == 4'd9) begin
            r = s;
        end else if (s.ones == 4'd9) begin
            r.ones = 4'd0;
            r.tens = s.tens + 4'd1;
        end else begin
            r.ones = s.ones + 4'd1;
        end
        return r;
    endfunction

    function automatic score_t to_bcd(input int unsigned v);
        score_t r;
        r.tens = bcd_t'((v / 10) % 10);
        r.ones = bcd_t'(v % 10);
        return r;
    endfunction

endpackage

// File: rtl/bcd_counter2.sv
// Two-digit saturating BCD score counter; clr takes priority over inc.
module bcd_counter2
    import pong_pkg::*;
(
    input  logic   clk,
    input  logic   reset,
    input  logic   inc,
    input  logic   clr,
    output score_t score
);

    score_t score_q;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            score_q <= '0;
        end else if (clr) begin
            score_q <= '0;
        end else if (inc) begin
            score_q <= bcd_inc(score_q);
        end
    end

    assign score = score_q;

endmodule

// File: rtl/score_keeper.sv
// Pong score keeper: per-player BCD scores, post-point hold-off and game-over.
// Optional blink of the loser's digits in OVER is enabled by SCORE_BLINK_EN.
module score_keeper
    import pong_pkg::*;
#(
    parameter int unsigned WIN_SCORE = 11,
    parameter int unsigned HOLDOFF   = 25_000_000,
    parameter int unsigned BLINK_DIV = 12_500_000
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       point_p1,
    input  logic       point_p2,
    input  logic       new_game,
    output logic [3:0] first_1,
    output logic [3:0] first_0,
    output logic [3:0] second_1,
    output logic [3:0] second_0,
    output logic       serve_ok,
    output logic       game_over,
    output logic       winner,
    output logic       blank
);

    localparam int unsigned HoldW  = (HOLDOFF > 1) ? $clog2(HOLDOFF) : 1;
    localparam score_t      WinBcd = to_bcd(WIN_SCORE);

    state_e           state_q, state_d;
    logic [HoldW-1:0] hold_q, hold_d;
    logic             winner_q, winner_d;
    logic             serve_ok_q, serve_ok_d;
    logic             game_over_q, game_over_d;
    logic             inc_p1, inc_p2, clr_scores;
    score_t           score_p1, score_p2;

    bcd_counter2 u_cnt_p1 (
        .clk   (clk),
        .reset (reset),
        .inc   (inc_p1),
        .clr   (clr_scores),
        .score (score_p1)
    );

    bcd_counter2 u_cnt_p2 (
        .clk   (clk),
        .reset (reset),
        .inc   (inc_p2),
        .clr   (clr_scores),
        .score (score_p2)
    );

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q  <= StIdle;
            hold_q   <= '0;
            winner_q <= 1'b0;
        end else begin
            state_q  <= state_d;
            hold_q   <= hold_d;
            winner_q <= winner_d;
        end
    end

    always_comb begin
        state_d    = state_q;
        winner_d   = winner_q;
        inc_p1     = 1'b0;
        inc_p2     = 1'b0;
        clr_scores = 1'b0;
        if (new_game) begin
            clr_scores = 1'b1;
            winner_d   = 1'b0;
            state_d    = StPlay;
        end else begin
            unique case (state_q)
                StIdle: ;
                StPlay: begin
                    if (point_p1 && point_p2) begin
                        state_d = StHold;
                    end else if (point_p1) begin
                        inc_p1  = 1'b1;
                        state_d = StHold;
                        if (bcd_inc(score_p1) == WinBcd) begin
                            state_d  = StOver;
                            winner_d = 1'b0;
                        end
                    end else if (point_p2) begin
                        inc_p2  = 1'b1;
                        state_d = StHold;
                        if (bcd_inc(score_p2) == WinBcd) begin
                            state_d  = StOver;
                            winner_d = 1'b1;
                        end
                    end
                end
                StHold: begin
                    if (hold_q == '0) state_d = StPlay;
                end
                StOver: ;
                default: state_d = StIdle;
            endcase
        end

        // Counter is zero outside HOLD so a later entry never sees a residual count.
        if (state_d != StHold) begin
            hold_d = '0;
        end else if (state_q != StHold) begin
            hold_d = HoldW'(HOLDOFF - 1);
        end else begin
            hold_d = hold_q - 1'b1;
        end
    end

    always_comb begin
        serve_ok_d  = (state_d == StPlay);
        game_over_d = (state_d == StOver);
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            serve_ok_q  <= 1'b0;
            game_over_q <= 1'b0;
        end else begin
            serve_ok_q  <= serve_ok_d;
            game_over_q <= game_over_d;
        end
    end

`ifdef SCORE_BLINK_EN
    localparam int unsigned BlinkW = (BLINK_DIV > 1) ? $clog2(BLINK_DIV) : 1;

    logic [BlinkW-1:0] blink_q;
    logic              blank_q;

    // Blink phase restarts at blank=0 on each entry to OVER.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            blink_q <= '0;
            blank_q <= 1'b0;
        end else if (state_d != StOver || state_q != StOver) begin
            blink_q <= '0;
            blank_q <= 1'b0;
        end else if (blink_q == BlinkW'(BLINK_DIV - 1)) begin
            blink_q <= '0;
            blank_q <= ~blank_q;
        end else begin
            blink_q <= blink_q + 1'b1;
        end
    end

    assign blank = blank_q;
`else
    logic unused_blink_div;
    assign unused_blink_div = ^BLINK_DIV;
    assign blank            = 1'b0;
`endif

    assign first_1   = score_p1.tens;
    assign first_0   = score_p1.ones;
    assign second_1  = score_p2.tens;
    assign second_0  = score_p2.ones;
    assign serve_ok  = serve_ok_q;
    assign game_over = game_over_q;
    assign winner    = winner_q;

endmodule

// File: tb/tb_score_keeper.sv
// Self-checking bench for score_keeper: scoreboarded point/new_game steps on two
// configurations plus a standalone saturation check of bcd_counter2.
module tb_score_keeper;
    import pong_pkg::*;

    localparam int unsigned HoldOff = 4;

    logic clk = 1'b0;
    logic reset = 1'b0;
    logic a_p1 = 1'b0, a_p2 = 1'b0, a_ng = 1'b0;
    logic b_p1 = 1'b0, b_p2 = 1'b0, b_ng = 1'b0;
    logic [3:0] a_f1, a_f0, a_s1, a_s0, b_f1, b_f0, b_s1, b_s0;
    logic a_serve, a_go, a_win, a_blank, b_serve, b_go, b_win, b_blank;
    logic sat_inc = 1'b0, sat_clr = 1'b0;
    score_t sat_score;

    int n_checks = 0;
    int n_fail = 0;

    typedef struct {
        string    tag;
        bit       sel;
        logic [3:0] f1, f0, s1, s0;
        logic     go, win;
    } exp_t;
    exp_t sb[$];

    always #5 clk = ~clk;

    score_keeper #(.WIN_SCORE(3), .HOLDOFF(HoldOff), .BLINK_DIV(2)) u_a (
        .clk(clk), .reset(reset), .point_p1(a_p1), .point_p2(a_p2), .new_game(a_ng),
        .first_1(a_f1), .first_0(a_f0), .second_1(a_s1), .second_0(a_s0),
        .serve_ok(a_serve), .game_over(a_go), .winner(a_win), .blank(a_blank)
    );

    score_keeper #(.WIN_SCORE(99), .HOLDOFF(HoldOff), .BLINK_DIV(2)) u_b (
        .clk(clk), .reset(reset), .point_p1(b_p1), .point_p2(b_p2), .new_game(b_ng),
        .first_1(b_f1), .first_0(b_f0), .second_1(b_s1), .second_0(b_s0),
        .serve_ok(b_serve), .game_over(b_go), .winner(b_win), .blank(b_blank)
    );

    bcd_counter2 u_sat (
        .clk(clk), .reset(reset), .inc(sat_inc), .clr(sat_clr), .score(sat_score)
    );

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    function automatic logic serve_of(input bit sel);
        return sel ? b_serve : a_serve;
    endfunction

    task automatic push_exp(input string tag, input bit sel, input int p1, input int p2,
                            input logic go, input logic win);
        exp_t e;
        e.tag = tag;
        e.sel = sel;
        e.f1  = 4'(p1 / 10);
        e.f0  = 4'(p1 % 10);
        e.s1  = 4'(p2 / 10);
        e.s0  = 4'(p2 % 10);
        e.go  = go;
        e.win = win;
        sb.push_back(e);
    endtask

    task automatic drive(input bit sel, input logic p1, input logic p2, input logic ng);
        @(negedge clk);
        if (sel) begin b_p1 = p1; b_p2 = p2; b_ng = ng; end
        else     begin a_p1 = p1; a_p2 = p2; a_ng = ng; end
        @(posedge clk);
        #1;
        a_p1 = 1'b0; a_p2 = 1'b0; a_ng = 1'b0;
        b_p1 = 1'b0; b_p2 = 1'b0; b_ng = 1'b0;
    endtask

    task automatic compare_out();
        exp_t e;
        logic [3:0] f1, f0, s1, s0;
        logic go, win;
        if (sb.size() == 0) begin
            check_eq("scoreboard_empty", 32'd0, 32'd1);
        end else begin
            e = sb.pop_front();
            if (e.sel) begin
                f1 = b_f1; f0 = b_f0; s1 = b_s1; s0 = b_s0; go = b_go; win = b_win;
            end else begin
                f1 = a_f1; f0 = a_f0; s1 = a_s1; s0 = a_s0; go = a_go; win = a_win;
            end
            check_eq({e.tag, "_p1"}, 32'({f1, f0}), 32'({e.f1, e.f0}));
            check_eq({e.tag, "_p2"}, 32'({s1, s0}), 32'({e.s1, e.s0}));
            check_eq({e.tag, "_go"}, 32'(go), 32'(e.go));
            check_eq({e.tag, "_win"}, 32'(win), 32'(e.win));
        end
    endtask

    task automatic step(input string tag, input bit sel, input logic p1, input logic p2,
                        input logic ng, input int e1, input int e2, input logic go,
                        input logic win);
        push_exp(tag, sel, e1, e2, go, win);
        drive(sel, p1, p2, ng);
        compare_out();
    endtask

    // Cycles serve_ok stays low from now, bounded so a stuck DUT still finishes.
    task automatic count_hold(input bit sel, output int n);
        n = 0;
        while (serve_of(sel) == 1'b0 && n < 40) begin
            n++;
            @(posedge clk);
            #1;
        end
    endtask

    initial begin
        int n;
        #2 reset = 1'b1;
        #1;
        check_eq("rst_digits", 32'({a_f1, a_f0, a_s1, a_s0}), 32'd0);
        check_eq("rst_serve", 32'(a_serve), 32'd0);
        check_eq("rst_go_win", 32'({a_go, a_win}), 32'd0);
        check_eq("rst_blank", 32'(a_blank), 32'd0);
        repeat (2) @(posedge clk);
        @(negedge clk);
        reset = 1'b0;

        step("idle_point", 0, 1, 0, 0, 0, 0, 0, 0);
        check_eq("idle_serve", 32'(a_serve), 32'd0);

        // Three spaced points on B, one extra point landing inside HOLD.
        step("b_new", 1, 0, 0, 1, 0, 0, 0, 0);
        check_eq("b_new_serve", 32'(b_serve), 32'd1);
        for (int i = 1; i <= 3; i++) begin
            step($sformatf("b_pt%0d", i), 1, 1, 0, 0, i, 0, 0, 0);
            if (i == 2) begin
                step("b_in_hold", 1, 0, 1, 0, i, 0, 0, 0);
                count_hold(1, n);
                check_eq("b_hold_rest", 32'(n), 32'(HoldOff - 1));
            end else begin
                count_hold(1, n);
                check_eq($sformatf("b_hold%0d", i), 32'(n), 32'(HoldOff));
            end
        end

        step("b_let", 1, 1, 1, 0, 3, 0, 0, 0);
        count_hold(1, n);
        check_eq("b_let_hold", 32'(n), 32'(HoldOff));

        for (int i = 4; i <= 10; i++) begin
            step($sformatf("b_pt%0d", i), 1, 1, 0, 0, i, 0, 0, 0);
            count_hold(1, n);
        end
        check_eq("b_ten_hold", 32'(n), 32'(HoldOff));

        step("b_ng_prio", 1, 1, 0, 1, 0, 0, 0, 0);
        check_eq("b_ng_serve", 32'(b_serve), 32'd1);

        // Player 2 wins A at 3.
        step("a_new", 0, 0, 0, 1, 0, 0, 0, 0);
        for (int i = 1; i <= 2; i++) begin
            step($sformatf("a_p2_%0d", i), 0, 0, 1, 0, 0, i, 0, 0);
            count_hold(0, n);
            check_eq($sformatf("a_hold%0d", i), 32'(n), 32'(HoldOff));
        end
        step("a_win", 0, 0, 1, 0, 0, 3, 1, 1);
        check_eq("a_over_serve", 32'(a_serve), 32'd0);
        for (int k = 0; k < 6; k++) begin
`ifdef SCORE_BLINK_EN
            check_eq($sformatf("blink%0d", k), 32'(a_blank), 32'((k / 2) % 2));
`else
            check_eq($sformatf("blink%0d", k), 32'(a_blank), 32'd0);
`endif
            @(posedge clk);
            #1;
        end
        step("a_over_p2", 0, 0, 1, 0, 0, 3, 1, 1);
        step("a_over_p1", 0, 1, 0, 0, 0, 3, 1, 1);
        step("a_regame", 0, 0, 0, 1, 0, 0, 0, 0);
        check_eq("a_regame_blank", 32'(a_blank), 32'd0);
        check_eq("a_regame_serve", 32'(a_serve), 32'd1);

        // Reset in the middle of HOLD.
        step("a_pre_rst", 0, 1, 0, 0, 1, 0, 0, 0);
        @(posedge clk);
        @(negedge clk);
        reset = 1'b1;
        #1;
        check_eq("hold_rst_digits", 32'({a_f1, a_f0, a_s1, a_s0}), 32'd0);
        check_eq("hold_rst_serve", 32'(a_serve), 32'd0);
        @(posedge clk);
        @(negedge clk);
        reset = 1'b0;
        repeat (6) @(posedge clk);
        #1;
        check_eq("post_rst_idle", 32'(a_serve), 32'd0);
        step("post_rst_pt", 0, 1, 0, 0, 0, 0, 0, 0);
        check_eq("post_rst_pt_serve", 32'(a_serve), 32'd0);
        step("post_rst_ng", 0, 0, 0, 1, 0, 0, 0, 0);
        check_eq("post_rst_ng_serve", 32'(a_serve), 32'd1);
        step("post_rst_pt2", 0, 1, 0, 0, 1, 0, 0, 0);
        count_hold(0, n);
        check_eq("post_rst_hold", 32'(n), 32'(HoldOff));

        // Saturation of the BCD counter at 99.
        @(negedge clk);
        sat_inc = 1'b1;
        repeat (99) @(posedge clk);
        #1;
        check_eq("sat_99", 32'(sat_score), 32'h99);
        repeat (6) @(posedge clk);
        #1;
        check_eq("sat_hold99", 32'(sat_score), 32'h99);
        sat_clr = 1'b1;
        @(posedge clk);
        #1;
        check_eq("sat_clr_prio", 32'(sat_score), 32'h00);
        sat_inc = 1'b0;
        sat_clr = 1'b0;

        check_eq("sb_drained", 32'(sb.size()), 32'd0);
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1);
    end

endmodule
